// File: rtl/clb_cfg_loader.sv
// Purpose : load a DATA_W-wide pad bitstream, verify its XOR checksum, shift it serially into the CLB chain, then latch it and enable the fabric.
// Latency : a pad strobe rise is acted on 3 clk_i later; the first chain shift is the cycle after capture; one bit per cycle.
// Backpress: none; a strobe edge during shifting is an overrun and lands in sticky ERROR until mode is released.
//
// Ports:
//   clk_i, rst_i        core clock, synchronous active-high reset
//   pad_cfg_mode_i      async session request (synchronized here)
//   pad_cfg_strobe_i    async word strobe, rising edge = new word on pad_cfg_data_i
//   pad_cfg_data_i      async word, held stable well before strobe rises
//   chain_shift_o/bit_o serial config chain interface, LSB of each word first
//   chain_latch_o       one-cycle pulse committing the chain to active config
//   clb_en_o            user fabric enable, high only after a verified load
//   cfg_busy_o/done_o/err_o  session status flags
module clb_cfg_loader #(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pad_cfg_mode_i,
    input  logic              pad_cfg_strobe_i,
    input  logic [DATA_W-1:0] pad_cfg_data_i,
    output logic              chain_shift_o,
    output logic              chain_bit_o,
    output logic              chain_latch_o,
    output logic              clb_en_o,
    output logic              cfg_busy_o,
    output logic              cfg_done_o,
    output logic              cfg_err_o
);

    localparam int NWORDS = (CHAIN_LEN + DATA_W - 1) / DATA_W;
    localparam int LASTN  = CHAIN_LEN - (NWORDS - 1) * DATA_W;
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int BCW    = $clog2(DATA_W + 1);

    localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);
    localparam logic [BCW-1:0] FULL_TOP  = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] LAST_TOP  = BCW'(LASTN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_WORD,
        ST_SHIFT,
        ST_WAIT_CSUM,
        ST_LATCH,
        ST_ERROR,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic              mode_m1, mode_s;
    logic              strb_m1, strb_s, strb_prev;
    logic              strb_edge;

    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]    bit_top;
    logic [DATA_W-1:0] word_sh;

    // Two-flop synchronizers for the pad controls, plus one history flop
    // on the strobe so a rising edge produces a single-cycle event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_m1   <= 1'b0;
            mode_s    <= 1'b0;
            strb_m1   <= 1'b0;
            strb_s    <= 1'b0;
            strb_prev <= 1'b0;
        end else begin
            mode_m1   <= pad_cfg_mode_i;
            mode_s    <= mode_m1;
            strb_m1   <= pad_cfg_strobe_i;
            strb_s    <= strb_m1;
            strb_prev <= strb_s;
        end
    end

    assign strb_edge = strb_s & ~strb_prev;

    // The final word only contributes LASTN bits to the chain; its upper
    // bits are dropped from the shift but still count toward the checksum.
    assign bit_top = (word_cnt_q == LAST_WORD) ? LAST_TOP : FULL_TOP;

    // Next-state logic. pad_cfg_data_i is sampled directly without a
    // synchronizer: it has been stable for several cycles by the time the
    // synchronized strobe edge arrives. Dropping mode aborts an open session
    // and takes priority over overrun and checksum outcomes.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        csum_d     = csum_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (mode_s) begin
                    state_d    = ST_WAIT_WORD;
                    word_cnt_d = '0;
                    csum_d     = '0;
                end
            end

            ST_WAIT_WORD: begin
                if (!mode_s) begin
                    state_d = ST_IDLE;
                end else if (strb_edge) begin
                    word_d    = pad_cfg_data_i;
                    csum_d    = csum_q ^ pad_cfg_data_i;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (!mode_s) begin
                    state_d = ST_IDLE;
                end else if (strb_edge) begin
                    state_d = ST_ERROR;
                end else if (bit_cnt_q == bit_top) begin
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = ST_WAIT_CSUM;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                        state_d    = ST_WAIT_WORD;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end

            ST_WAIT_CSUM: begin
                if (!mode_s) begin
                    state_d = ST_IDLE;
                end else if (strb_edge) begin
                    state_d = (pad_cfg_data_i == csum_q) ? ST_LATCH : ST_ERROR;
                end
            end

            ST_LATCH: begin
                state_d = ST_RUN;
            end

            ST_ERROR: begin
                if (!mode_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bit presented on the chain during the cycle that state_d describes.
    assign word_sh = word_d >> bit_cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            csum_q     <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state they describe, with no combinational path to the pins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_shift_o <= 1'b0;
            chain_bit_o   <= 1'b0;
            chain_latch_o <= 1'b0;
            clb_en_o      <= 1'b0;
            cfg_busy_o    <= 1'b0;
            cfg_done_o    <= 1'b0;
            cfg_err_o     <= 1'b0;
        end else begin
            chain_shift_o <= (state_d == ST_SHIFT);
            chain_bit_o   <= (state_d == ST_SHIFT) & word_sh[0];
            chain_latch_o <= (state_d == ST_LATCH);
            clb_en_o      <= (state_d == ST_RUN);
            cfg_busy_o    <= (state_d == ST_WAIT_WORD) ||
                             (state_d == ST_SHIFT) ||
                             (state_d == ST_WAIT_CSUM);
            cfg_done_o    <= (state_d == ST_RUN);
            cfg_err_o     <= (state_d == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
module tb_clb_cfg_loader;

    localparam int DATA_W    = 8;
    localparam int CHAIN_LEN = 20;
    localparam int NWORDS    = (CHAIN_LEN + DATA_W - 1) / DATA_W;
    localparam int LASTN     = CHAIN_LEN - (NWORDS - 1) * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mode = 1'b0;
    logic              strobe = 1'b0;
    logic [DATA_W-1:0] data = '0;

    logic chain_shift_o, chain_bit_o, chain_latch_o, clb_en_o;
    logic cfg_busy_o, cfg_done_o, cfg_err_o;

    clb_cfg_loader #(.DATA_W(DATA_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pad_cfg_mode_i   (mode),
        .pad_cfg_strobe_i (strobe),
        .pad_cfg_data_i   (data),
        .chain_shift_o    (chain_shift_o),
        .chain_bit_o      (chain_bit_o),
        .chain_latch_o    (chain_latch_o),
        .clb_en_o         (clb_en_o),
        .cfg_busy_o       (cfg_busy_o),
        .cfg_done_o       (cfg_done_o),
        .cfg_err_o        (cfg_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int latch_seen = 0;
    bit exp_bits[$];
    bit got_bits[$];
    logic prev_latch = 1'b0;

    task automatic ck(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: the chain must receive, in order, the low n bits of
    // each data word (n = DATA_W, or LASTN for the final word), LSB first.
    task automatic expect_word_bits(input logic [7:0] w, input int idx, input int nmax);
        int n;
        n = (idx == NWORDS - 1) ? LASTN : DATA_W;
        if (nmax < n) n = nmax;
        for (int i = 0; i < n; i++) exp_bits.push_back(w[i]);
    endtask

    function automatic logic [7:0] model_csum(input logic [7:0] w[3]);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 3; i++) c = c ^ w[i];
        return c;
    endfunction

    // Per-cycle comparison against the model plus status invariants.
    always @(negedge clk) begin
        if (chain_shift_o) begin
            got_bits.push_back(chain_bit_o);
            if (exp_bits.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_shift got=shift expected=no_shift");
            end else begin
                ck("chain_bit", chain_bit_o, exp_bits.pop_front());
            end
        end
        if (chain_latch_o) latch_seen++;
        ck("en_matches_done", clb_en_o, cfg_done_o);
        ck("status_onehot", (int'(cfg_busy_o) + int'(cfg_done_o) + int'(cfg_err_o)) <= 1, 1);
        ck("latch_isolated", chain_latch_o && (chain_shift_o || prev_latch), 0);
        prev_latch <= chain_latch_o;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        mode = 1'b1;
        cyc(4);
    endtask

    task automatic send_word(input logic [7:0] w, input bit drop_mode);
        data = w;
        cyc(4);
        strobe = 1'b1;
        cyc(1);
        if (drop_mode) mode = 1'b0;
        cyc(1);
        strobe = 1'b0;
        cyc(14);
    endtask

    task automatic load(input logic [7:0] w[3], input logic [7:0] cs, input bit drop);
        for (int i = 0; i < 3; i++) begin
            expect_word_bits(w[i], i, DATA_W);
            send_word(w[i], 1'b0);
        end
        send_word(cs, drop);
    endtask

    task automatic check_status(input string tag, input bit busy, input bit done, input bit err);
        ck({tag, "_busy"}, cfg_busy_o, busy);
        ck({tag, "_done"}, cfg_done_o, done);
        ck({tag, "_err"}, cfg_err_o, err);
        ck({tag, "_en"}, clb_en_o, done);
    endtask

    task automatic release_mode();
        mode = 1'b0;
        cyc(5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w[3];
        logic [7:0] cs;
        bit lit[20];
        bit model_q[$];
        int lbefore;
        int choice;
        int abort_after;

        lit = '{1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1,1,1,1};

        // Reset state
        cyc(3);
        ck("rst_shift", chain_shift_o, 0);
        ck("rst_bit", chain_bit_o, 0);
        ck("rst_latch", chain_latch_o, 0);
        check_status("rst", 0, 0, 0);
        rst = 1'b0;
        cyc(2);

        // Model pins against hand-computed values
        w = '{8'hA5, 8'h3C, 8'h0F};
        ck("model_csum_t1", model_csum(w), 8'h96);
        for (int i = 0; i < 3; i++) expect_word_bits(w[i], i, DATA_W);
        model_q = exp_bits;
        exp_bits.delete();
        ck("model_len_t1", model_q.size(), 20);
        for (int i = 0; i < 20 && i < model_q.size(); i++) ck("model_bit_t1", model_q[i], lit[i]);

        // 1: good load
        got_bits.delete();
        lbefore = latch_seen;
        start_session();
        check_status("t1_start", 1, 0, 0);
        load(w, 8'h96, 1'b1);
        ck("t1_nshift", got_bits.size(), 20);
        for (int i = 0; i < 20 && i < got_bits.size(); i++) ck("t1_bit_literal", got_bits[i], lit[i]);
        ck("t1_latch", latch_seen - lbefore, 1);
        check_status("t1_end", 0, 1, 0);

        // 2: bad checksum
        lbefore = latch_seen;
        start_session();
        check_status("t2_from_run", 1, 0, 0);
        load(w, 8'h97, 1'b0);
        check_status("t2_err", 0, 0, 1);
        ck("t2_latch", latch_seen - lbefore, 0);
        release_mode();
        check_status("t2_idle", 0, 0, 0);

        // 3: last word 0xFF, only LASTN bits shifted
        w = '{8'hA5, 8'h3C, 8'hFF};
        ck("model_csum_t3", model_csum(w), 8'h66);
        got_bits.delete();
        lbefore = latch_seen;
        start_session();
        load(w, model_csum(w), 1'b1);
        ck("t3_nshift", got_bits.size(), 20);
        ck("t3_latch", latch_seen - lbefore, 1);
        check_status("t3_end", 0, 1, 0);

        // 4: overrun, second strobe edge two cycles after capture
        got_bits.delete();
        lbefore = latch_seen;
        start_session();
        expect_word_bits(8'hA5, 0, 2);
        data = 8'hA5;
        cyc(4);
        strobe = 1'b1; cyc(1);
        strobe = 1'b0; cyc(1);
        strobe = 1'b1; cyc(1);
        strobe = 1'b0; cyc(14);
        ck("t4_nshift", got_bits.size(), 2);
        check_status("t4_err", 0, 0, 1);
        ck("t4_latch", latch_seen - lbefore, 0);
        release_mode();
        check_status("t4_idle", 0, 0, 0);

        // 5: abort after word 1, then a fresh session from word 0
        lbefore = latch_seen;
        start_session();
        expect_word_bits(8'h5A, 0, DATA_W); send_word(8'h5A, 1'b0);
        expect_word_bits(8'hC3, 1, DATA_W); send_word(8'hC3, 1'b0);
        release_mode();
        check_status("t5_abort", 0, 0, 0);
        ck("t5_latch", latch_seen - lbefore, 0);
        w = '{8'h12, 8'h34, 8'h56};
        got_bits.delete();
        start_session();
        load(w, model_csum(w), 1'b1);
        ck("t5_nshift", got_bits.size(), 20);
        ck("t5_latch_new", latch_seen - lbefore, 1);
        check_status("t5_end", 0, 1, 0);

        // 6: reconfig from RUN drops enable, then reset mid-shift
        start_session();
        check_status("t6_reconfig", 1, 0, 0);
        expect_word_bits(8'hE7, 0, DATA_W);
        data = 8'hE7;
        cyc(4);
        strobe = 1'b1; cyc(2);
        strobe = 1'b0; cyc(3);
        rst = 1'b1;
        mode = 1'b0;
        @(negedge clk);
        ck("t6_was_shifting", chain_shift_o, 1);
        #1 exp_bits.delete();
        @(negedge clk);
        ck("t6_rst_shift", chain_shift_o, 0);
        ck("t6_rst_bit", chain_bit_o, 0);
        ck("t6_rst_latch", chain_latch_o, 0);
        check_status("t6_rst", 0, 0, 0);
        cyc(2);
        rst = 1'b0;
        cyc(4);
        check_status("t6_post_rst", 0, 0, 0);

        // Randomized sessions against the model
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 3; i++) w[i] = 8'($urandom_range(0, 255));
            choice = $urandom_range(0, 2);
            lbefore = latch_seen;
            start_session();
            if (choice == 0) begin
                load(w, model_csum(w), 1'b1);
                ck("rnd_good_latch", latch_seen - lbefore, 1);
                check_status("rnd_good", 0, 1, 0);
            end else if (choice == 1) begin
                cs = model_csum(w) ^ 8'($urandom_range(1, 255));
                load(w, cs, 1'b0);
                ck("rnd_bad_latch", latch_seen - lbefore, 0);
                check_status("rnd_bad", 0, 0, 1);
                release_mode();
                check_status("rnd_bad_idle", 0, 0, 0);
            end else begin
                abort_after = $urandom_range(1, 3);
                for (int i = 0; i < abort_after; i++) begin
                    expect_word_bits(w[i], i, DATA_W);
                    send_word(w[i], 1'b0);
                end
                release_mode();
                ck("rnd_abort_latch", latch_seen - lbefore, 0);
                check_status("rnd_abort", 0, 0, 0);
            end
        end

        cyc(4);
        ck("leftover_bits", exp_bits.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
